// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port, shared by writeback sources A and B.
// Define WB_SCOREBOARD_EN to build the outstanding-write scoreboard that drives o_busy.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter bit FIRST_GRANT = 1'b0
) (
    input  logic                  i_clock,
    input  logic                  i_ctrl_reset,
    input  logic                  i_a_valid,
    input  logic [4:0]            i_a_reg,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    output logic                  o_a_ready,
    input  logic                  i_b_valid,
    input  logic [4:0]            i_b_reg,
    input  logic [DATA_WIDTH-1:0] i_b_data,
    output logic                  o_b_ready,
    output logic                  o_wr_en,
    output logic [4:0]            o_wr_reg,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [31:0]           o_wr_onehot,
    input  logic                  i_issue_en,
    input  logic [4:0]            i_issue_reg,
    output logic [31:0]           o_busy
);

    logic                  r_last_grant;
    logic                  r_wr_en;
    logic [4:0]            r_wr_reg;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [31:0]           r_wr_onehot;

    logic                  w_grant_a;
    logic                  w_grant_b;
    logic                  w_transfer;
    logic [4:0]            w_sel_reg;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [31:0]           w_onehot_next;

    // last_grant: 0 = A won last, 1 = B won last. Contested cycles go to the other one.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!i_ctrl_reset) begin
            w_grant_a = i_a_valid && (!i_b_valid || r_last_grant);
            w_grant_b = i_b_valid && (!i_a_valid || !r_last_grant);
        end
    end

    assign w_transfer = w_grant_a || w_grant_b;
    assign w_sel_reg  = w_grant_b ? i_b_reg  : i_a_reg;
    assign w_sel_data = w_grant_b ? i_b_data : i_a_data;

    // Register 0 decodes to nothing, so a write to it completes the handshake but never lands.
    always_comb begin
        w_onehot_next = '0;
        if (w_transfer) begin
            w_onehot_next = (32'd1 << w_sel_reg) & ~32'd1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_ctrl_reset) begin
            r_last_grant <= ~FIRST_GRANT;
            r_wr_en      <= 1'b0;
            r_wr_reg     <= '0;
            r_wr_data    <= '0;
            r_wr_onehot  <= '0;
        end else begin
            r_wr_en     <= |w_onehot_next;
            r_wr_onehot <= w_onehot_next;
            if (w_transfer) begin
                r_last_grant <= w_grant_b;
                r_wr_reg     <= w_sel_reg;
                r_wr_data    <= w_sel_data;
            end
        end
    end

    assign o_a_ready   = w_grant_a;
    assign o_b_ready   = w_grant_b;
    assign o_wr_en     = r_wr_en;
    assign o_wr_reg    = r_wr_reg;
    assign o_wr_data   = r_wr_data;
    assign o_wr_onehot = r_wr_onehot;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] r_busy;
    logic [31:0] w_set_mask;

    always_comb begin
        w_set_mask = '0;
        if (i_issue_en) begin
            w_set_mask = (32'd1 << i_issue_reg) & ~32'd1;
        end
    end

    // Clear uses the decode being captured this edge; a same-edge issue re-sets the bit.
    always_ff @(posedge i_clock) begin
        if (i_ctrl_reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_onehot_next) | w_set_mask) & ~32'd1;
        end
    end

    assign o_busy = r_busy;
`else
    logic w_unused_issue;
    assign w_unused_issue = ^{i_issue_en, i_issue_reg};
    assign o_busy         = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter (FIRST_GRANT=0, DATA_WIDTH=32).
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, issue_en;
    logic [4:0]  a_reg, b_reg, issue_reg;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data, wr_onehot, busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_WIDTH(32), .FIRST_GRANT(1'b0)) dut (
        .i_clock(clk), .i_ctrl_reset(rst),
        .i_a_valid(a_valid), .i_a_reg(a_reg), .i_a_data(a_data), .o_a_ready(a_ready),
        .i_b_valid(b_valid), .i_b_reg(b_reg), .i_b_data(b_data), .o_b_ready(b_ready),
        .o_wr_en(wr_en), .o_wr_reg(wr_reg), .o_wr_data(wr_data), .o_wr_onehot(wr_onehot),
        .i_issue_en(issue_en), .i_issue_reg(issue_reg), .o_busy(busy)
    );

    // Inputs applied in a cycle, and the outputs expected at that cycle's falling edge
    // (readies from this cycle's inputs, write outputs from the previous edge).
    typedef struct packed {
        logic        rst;
        logic        av;
        logic [4:0]  areg;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  breg;
        logic [31:0] bd;
        logic        ien;
        logic [4:0]  ireg;
        logic        ar;
        logic        br;
        logic        wen;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [31:0] onehot;
        logic [31:0] busy;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t v(input logic r, input logic av, input logic [4:0] ar_, input logic [31:0] ad,
                               input logic bv, input logic [4:0] br_, input logic [31:0] bd,
                               input logic ie, input logic [4:0] ir,
                               input logic ea, input logic eb, input logic ew, input logic [4:0] ewr,
                               input logic [31:0] ewd, input logic [31:0] eoh, input logic [31:0] ebusy);
        vec_t t;
        t = '{rst:r, av:av, areg:ar_, ad:ad, bv:bv, breg:br_, bd:bd, ien:ie, ireg:ir,
              ar:ea, br:eb, wen:ew, wreg:ewr, wdata:ewd, onehot:eoh, busy:ebusy};
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
    endtask

    function automatic logic [31:0] bexp(input logic [31:0] b);
`ifdef WB_SCOREBOARD_EN
        return b;
`else
        return (b & 32'd0);
`endif
    endfunction

    task automatic drive(input logic r, input logic av, input logic [4:0] ar_, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br_, input logic [31:0] bd,
                         input logic ie, input logic [4:0] ir);
        rst = r; a_valid = av; a_reg = ar_; a_data = ad;
        b_valid = bv; b_reg = br_; b_data = bd; issue_en = ie; issue_reg = ir;
    endtask

    task automatic check_all(input int idx, input logic ea, input logic eb, input logic ew,
                             input logic [4:0] ewr, input logic [31:0] ewd,
                             input logic [31:0] eoh, input logic [31:0] ebusy);
        chk("a_ready",   idx, {31'd0, a_ready}, {31'd0, ea});
        chk("b_ready",   idx, {31'd0, b_ready}, {31'd0, eb});
        chk("wr_en",     idx, {31'd0, wr_en},   {31'd0, ew});
        chk("wr_reg",    idx, {27'd0, wr_reg},  {27'd0, ewr});
        chk("wr_data",   idx, wr_data, ewd);
        chk("wr_onehot", idx, wr_onehot, eoh);
        chk("busy",      idx, busy, bexp(ebusy));
    endtask

    initial begin
        //            rst av areg ad            bv breg bd        ien ireg   ar br wen wreg wdata         onehot        busy
        vecs[0]  = v(1, 1, 5, 32'hDEADBEEF, 1, 7, 32'h77,   0, 0,   0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
        vecs[1]  = v(1, 1, 5, 32'hDEADBEEF, 1, 7, 32'h77,   0, 0,   0, 0, 0, 0, 32'h0,        32'h0,        32'h0);
        vecs[2]  = v(0, 1, 5, 32'hDEADBEEF, 1, 7, 32'h77,   0, 0,   1, 0, 0, 0, 32'h0,        32'h0,        32'h0);
        vecs[3]  = v(0, 0, 0, 32'h0,        1, 7, 32'h77,   0, 0,   0, 1, 1, 5, 32'hDEADBEEF, 32'h20,       32'h0);
        vecs[4]  = v(0, 1, 3, 32'h33,       1, 7, 32'h77,   0, 0,   1, 0, 1, 7, 32'h77,       32'h80,       32'h0);
        vecs[5]  = v(0, 1, 3, 32'h33,       1, 7, 32'h77,   0, 0,   0, 1, 1, 3, 32'h33,       32'h08,       32'h0);
        vecs[6]  = v(0, 1, 3, 32'h33,       1, 7, 32'h77,   0, 0,   1, 0, 1, 7, 32'h77,       32'h80,       32'h0);
        vecs[7]  = v(0, 1, 3, 32'h33,       1, 7, 32'h77,   0, 0,   0, 1, 1, 3, 32'h33,       32'h08,       32'h0);
        vecs[8]  = v(0, 0, 0, 32'h0,        1, 0, 32'h1234, 1, 0,   0, 1, 1, 7, 32'h77,       32'h80,       32'h0);
        vecs[9]  = v(0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 9,   0, 0, 0, 0, 32'h1234,     32'h0,        32'h0);
        vecs[10] = v(0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0,   0, 0, 0, 0, 32'h1234,     32'h0,        32'h200);
        vecs[11] = v(0, 1, 9, 32'h99,       0, 0, 32'h0,    1, 9,   1, 0, 0, 0, 32'h1234,     32'h0,        32'h200);
        vecs[12] = v(0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0,   0, 0, 1, 9, 32'h99,       32'h200,      32'h200);
        vecs[13] = v(0, 1, 9, 32'hAA,       0, 0, 32'h0,    0, 0,   1, 0, 0, 9, 32'h99,       32'h0,        32'h200);
        vecs[14] = v(0, 0, 0, 32'h0,        0, 0, 32'h0,    1, 4,   0, 0, 1, 9, 32'hAA,       32'h200,      32'h0);
        vecs[15] = v(1, 1, 4, 32'h44,       0, 0, 32'h0,    1, 4,   0, 0, 0, 9, 32'hAA,       32'h0,        32'h10);
        vecs[16] = v(0, 1, 4, 32'h44,       1, 6, 32'h66,   0, 0,   1, 0, 0, 0, 32'h0,        32'h0,        32'h0);
        vecs[17] = v(0, 0, 0, 32'h0,        1, 6, 32'h66,   0, 0,   0, 1, 1, 4, 32'h44,       32'h10,       32'h0);
        vecs[18] = v(0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0,   0, 0, 1, 6, 32'h66,       32'h40,       32'h0);
        vecs[19] = v(0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0,   0, 0, 0, 6, 32'h66,       32'h0,        32'h0);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].av, vecs[i].areg, vecs[i].ad,
                  vecs[i].bv, vecs[i].breg, vecs[i].bd, vecs[i].ien, vecs[i].ireg);
            @(negedge clk);
            check_all(i, vecs[i].ar, vecs[i].br, vecs[i].wen, vecs[i].wreg,
                      vecs[i].wdata, vecs[i].onehot, vecs[i].busy);
            @(posedge clk); #1;
        end

        // Captured write followed by reset: the write is visible, then wiped by the reset edge.
        drive(0, 1, 12, 32'hC0FFEE, 0, 0, 0, 1, 12);
        @(negedge clk);
        check_all(100, 1, 0, 0, 6, 32'h66, 32'h0, 32'h0);
        @(posedge clk); #1;
        drive(1, 1, 13, 32'h13, 1, 14, 32'h14, 0, 0);
        @(negedge clk);
        check_all(101, 0, 0, 1, 12, 32'hC0FFEE, 32'h1000, 32'h1000);
        @(posedge clk); #1;
        // Both still valid after reset: A wins again, nothing issues from before the reset.
        drive(0, 1, 13, 32'h13, 1, 14, 32'h14, 0, 0);
        @(negedge clk);
        check_all(102, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 1, 14, 32'h14, 0, 0);
        @(negedge clk);
        check_all(103, 0, 1, 1, 13, 32'h13, 32'h2000, 32'h0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_all(104, 0, 0, 1, 14, 32'h14, 32'h4000, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback sources: A (single-cycle ALU path) and B (multi-cycle mult/div and load path). Round-robin arbitration with a valid/ready handshake per requester. Registers the winning write and drives the register file's write controls, including the 32-bit one-hot write-enable vector, with register 0 always masked. An optional scoreboard tracks registers with writes still outstanding, for the stall logic.

## Interface
- DATA_WIDTH, 32, width of write data
- FIRST_GRANT, 0, requester that wins the first contested cycle after reset (0 = A, 1 = B)

- clock  in  1  single clock; all state updates on rising edge
- ctrl_reset  in  1  synchronous, active-high reset
- a_valid  in  1  A has a write pending
- a_reg  in  5  A destination register
- a_data  in  DATA_WIDTH  A write data
- a_ready  out  1  A accepted this cycle
- b_valid, b_reg, b_data, b_ready  same as A, for requester B
- wr_en  out  1  register file write enable
- wr_reg  out  5  register file write address
- wr_data  out  DATA_WIDTH  register file write data
- wr_onehot  out  32  decoded write enable; bit r = wr_en && wr_reg==r; bit 0 always 0
- issue_en  in  1  scoreboard: an instruction with a destination register issued
- issue_reg  in  5  scoreboard: destination register of that instruction
- busy  out  32  scoreboard: bit r = write to r outstanding

## Operation
- Transfer on a requester = valid && ready in the same cycle. A requester holds valid, reg and data stable until its transfer.
- Grant is combinational from valid and the 1-bit last_grant register:
  - One requester valid: that requester gets ready=1.
  - Both valid: the requester that is not last_grant gets ready=1.
  - Neither valid: both readys are 0.
- a_ready and b_ready are never both 1.
- last_grant updates to the granted requester on every transfer. Reset value = the requester that is not FIRST_GRANT.
- Output stage is registered:
  - wr_en <= transfer && granted reg != 0.
  - wr_reg and wr_data load on every transfer.
- A write to register 0 completes the handshake and is then dropped: wr_en=0 and wr_onehot=0.
- wr_onehot is registered alongside wr_en and is bit-consistent with wr_en/wr_reg every cycle.
- Reset values: a_ready=b_ready=0 while ctrl_reset=1; wr_en=0; wr_reg=0; wr_data=0; wr_onehot=0; busy=0; last_grant as above.
- Reset mid-operation: any captured write is discarded and no write issues on the cycle after reset. Requesters still valid re-arbitrate from the reset last_grant.

## Timing
- Latency: a transfer in cycle N produces wr_en=1 in cycle N+1 and wr_en=0 in N+2 unless another transfer occurs.
- Throughput: one write per cycle, sustained.
- Fairness: with A and B both continuously valid, grants alternate A,B,A,B… (FIRST_GRANT=0).
- Starvation: a requester waits at most 1 cycle.
- Scoreboard:
  - busy[issue_reg] set at the edge after issue_en && issue_reg != 0.
  - busy[r] cleared at the same edge that wr_en=1, wr_reg=r becomes visible, i.e. the edge after the transfer.
  - Simultaneous set and clear of the same r: set wins, busy[r]=1.
  - busy[0] is always 0.

## Configuration
- Macro WB_SCOREBOARD_EN.
- Defined: the scoreboard is built as described.
- Undefined: no scoreboard flops; busy is constant 0; issue_en and issue_reg are ignored. Arbitration and the write path are unchanged.

## Test plan
- Reset: hold ctrl_reset 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0 and all outputs 0 throughout. First cycle after reset: a_ready=1.
- A only: a_valid=1, a_reg=5, a_data=0xDEADBEEF in cycle N -> a_ready=1 in N. Cycle N+1: wr_en=1, wr_reg=5, wr_data=0xDEADBEEF, wr_onehot=0x00000020.
- Contention: A (reg 3) and B (reg 7) valid and held for 4 cycles -> grants A,B,A,B. Outputs show wr_reg=3,7,3,7 on the following cycles.
- Register 0: b_valid=1, b_reg=0, b_data=0x1234 -> b_ready=1, then next cycle wr_en=0, wr_onehot=0. With the macro defined, busy stays 0 after issue_en=1, issue_reg=0.
- Scoreboard: issue_en=1, issue_reg=9 in cycle N -> busy=0x00000200 from N+1. Then in one cycle, A transfers reg 9 and issue_en=1 with issue_reg=9 -> busy[9] remains 1.
- Reset mid-operation: A transfer in cycle N with ctrl_reset=1 in N -> wr_en=0 in N+1 and busy=0.
